// File: rtl/spi_pkg.sv
// Shared SPI memory definitions: transaction FSM state encoding and default field widths.
package spi_pkg;

   localparam int DEF_ADDR_BITS = 7;
   localparam int DEF_WORD_BITS = 8;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GET_ADDR    = 3'd1,
      GOT_ADDR    = 3'd2,
      READ_LOAD   = 3'd3,
      READ_SHIFT  = 3'd4,
      WRITE_SHIFT = 3'd5,
      WRITE_STORE = 3'd6,
      DONE        = 3'd7
   } spi_state_t;

   // Wide enough to hold the larger of the two phase lengths without wrapping.
   function automatic int cnt_width(input int addr_bits, input int word_bits);
      int longest;
      longest = ((addr_bits + 1) > word_bits) ? (addr_bits + 1) : word_bits;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK edge counter for one transaction phase; at_terminal flags that the next increment hits terminal.
module spi_bit_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [CNT_W-1:0] terminal,
   output logic             at_terminal
);

   logic [CNT_W-1:0] count;

   assign at_terminal = ((count + CNT_W'(1)) == terminal);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_transaction_fsm.sv
// SPI slave transaction sequencer: address+R/W byte, then one data byte; Moore outputs, all registered.
module spi_transaction_fsm
   import spi_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int WORD_BITS = DEF_WORD_BITS
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cs_n,
   input  logic sclk_posedge,
   input  logic sclk_negedge,
   input  logic rw_bit,
   output logic addr_we,
   output logic sr_we,
   output logic dm_we,
   output logic miso_bufe,
   output logic busy
);

   localparam int               CNT_W   = cnt_width(ADDR_BITS, WORD_BITS);
   localparam logic [CNT_W-1:0] ADDR_TC = CNT_W'(ADDR_BITS + 1);
   localparam logic [CNT_W-1:0] WORD_TC = CNT_W'(WORD_BITS);

   spi_state_t       state;
   logic             cnt_clear;
   logic             cnt_inc;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_term;

   // Only the edge that belongs to the current phase is counted; everything else is dropped.
   always_comb begin
      cnt_clear = cs_n || (state == IDLE) || (state == GOT_ADDR);
      cnt_inc   = ((state == GET_ADDR)    && sclk_posedge) ||
                  ((state == WRITE_SHIFT) && sclk_posedge) ||
                  ((state == READ_SHIFT)  && sclk_negedge);
      cnt_term  = (state == GET_ADDR) ? ADDR_TC : WORD_TC;
   end

   spi_bit_counter #(
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (cnt_clear),
      .inc         (cnt_inc),
      .terminal    (cnt_term),
      .at_terminal (cnt_tc)
   );

   // Outputs are assigned alongside the state they decode, so each equals a decode of the new state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_we   <= 1'b0;
         sr_we     <= 1'b0;
         dm_we     <= 1'b0;
         miso_bufe <= 1'b0;
         busy      <= 1'b0;
      end else begin
         addr_we   <= 1'b0;
         sr_we     <= 1'b0;
         dm_we     <= 1'b0;
         miso_bufe <= 1'b0;
         busy      <= 1'b1;
         if (cs_n) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= GET_ADDR;
               GET_ADDR: begin
                  if (sclk_posedge && cnt_tc) begin
                     state   <= GOT_ADDR;
                     addr_we <= 1'b1;
                  end
               end
               GOT_ADDR: begin
                  if (rw_bit) begin
                     state <= READ_LOAD;
                     sr_we <= 1'b1;
                  end else begin
                     state <= WRITE_SHIFT;
                  end
               end
               READ_LOAD: begin
                  state     <= READ_SHIFT;
                  miso_bufe <= 1'b1;
               end
               READ_SHIFT: begin
                  if (sclk_negedge && cnt_tc) begin
                     state <= DONE;
                  end else begin
                     miso_bufe <= 1'b1;
                  end
               end
               WRITE_SHIFT: begin
                  if (sclk_posedge && cnt_tc) begin
                     state <= WRITE_STORE;
                     dm_we <= 1'b1;
                  end
               end
               WRITE_STORE: state <= DONE;
               default:     state <= state;
            endcase
         end
      end
   end

endmodule
